// File: rtl/fifo_pkg.sv
// fifo_pkg: shared mode enum, pointer-width helper and X-scrub for the sync FIFO
package fifo_pkg;
  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic logic to01(input logic b);
    return b === 1'b1;
  endfunction
endpackage

// File: rtl/fifo_sdp_ram.sv
// fifo_sdp_ram: simple dual-port RAM, one write port, one registered read port
module fifo_sdp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // storage write; contents are never reset, pointers decide validity
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  // registered read sees the pre-write contents when addresses collide
  always_ff @(posedge clock or posedge reset)
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with count, almost flags and STD/FWFT read; FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
module fifo_sync_flags import fifo_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic                          full,
  output logic                          almost_full,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          empty,
  output logic                          almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
  input  logic                          err_clr,
  output logic                          overflow,
  output logic                          underflow,
`endif
  output logic [fifo_ptr_w(DEPTH)-1:0]  count
);
  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C = PW'(AE_THRESH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync_flags: DEPTH must be a power of 2 and >= 2");
  end
  if (AE_THRESH >= AF_THRESH) begin : g_bad_thresh
    $error("fifo_sync_flags: AE_THRESH must be below AF_THRESH");
  end

  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_n, count_n;
  logic wr_acc, rd_acc, byp, head_chg, ram_re, byp_sel;
  logic [AW-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_q, byp_data, dout_raw;

  // accept logic, next state, and FWFT head selection (bypass when the written word becomes head)
  always_comb begin
    rd_acc = rd_en && !empty;
    wr_acc = wr_en && (!full || rd_acc);
    rd_ptr_n = rd_ptr + PW'(rd_acc);
    count_n = count + PW'(wr_acc) - PW'(rd_acc);
    byp = wr_acc && (count == PW'(rd_acc));
    head_chg = (count_n != '0) && (rd_acc || empty);
    ram_re = (MODE == FIFO_FWFT) ? head_chg && !byp : rd_acc;
    ram_raddr = (MODE == FIFO_FWFT) ? rd_ptr_n[AW-1:0] : rd_ptr[AW-1:0];
    dout_raw = byp_sel ? byp_data : ram_q;
  end

  fifo_sdp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(AW)) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (din),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  // pointers, count and registered status flags reflecting post-edge occupancy
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr + PW'(wr_acc);
      rd_ptr <= rd_ptr_n;
      count <= count_n;
      full <= count_n == DEPTH_C;
      empty <= count_n == '0;
      almost_full <= count_n >= AF_C;
      almost_empty <= count_n <= AE_C;
    end

  // FWFT prefetch stage: captures din directly when it lands as the new head
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      byp_sel <= 1'b0;
      byp_data <= '0;
    end else if (MODE == FIFO_FWFT && head_chg) begin
      byp_sel <= byp;
      if (byp) byp_data <= din;
    end

  // scrub X to 0 so pre-reset or uninitialised RAM reads stay clean in simulation
  always_comb
    for (int i = 0; i < DATA_WIDTH; i++) dout[i] = to01(dout_raw[i]);

`ifdef FIFO_ERR_FLAGS_EN
  // sticky error flags; a new error in the clearing cycle keeps the flag set
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= (wr_en && !wr_acc) || (overflow && !err_clr);
      underflow <= (rd_en && empty) || (underflow && !err_clr);
    end
`endif
endmodule
